// File: rtl/spi_seq_pkg.sv
// Shared constants, FSM state encoding and command payload for the SPI command sequencer.
package spi_seq_pkg;

    localparam int unsigned cAddrWidth     = 7;
    localparam int unsigned cDataWidth     = 8;
    localparam int unsigned cFifoDepth     = 4;
    localparam int unsigned cGapCycles     = 4;
    localparam int unsigned cTimeoutCycles = 64;

    localparam int unsigned cFrameWidth = 1 + cAddrWidth + cDataWidth;
    localparam int unsigned cRwBit      = cFrameWidth - 1;
    localparam int unsigned cAddrMsb    = cFrameWidth - 2;
    localparam int unsigned cAddrLsb    = cDataWidth;
    localparam int unsigned cDataMsb    = cDataWidth - 1;
    localparam int unsigned cDataLsb    = 0;

    // Shared BUSY-timeout / GAP counter; wide enough to hold cTimeoutCycles.
    localparam int unsigned cCntWidth = $clog2(cTimeoutCycles) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_BUSY,
        ST_GAP
    } state_e;

    typedef struct packed {
        logic                  rw;
        logic [cAddrWidth-1:0] addr;
        logic [cDataWidth-1:0] wdata;
    } cmd_t;

    // Reads carry a zero data byte on the wire.
    function automatic logic [cFrameWidth-1:0] build_frame(input cmd_t cmd);
        logic [cDataWidth-1:0] data;
        data = cmd.rw ? '0 : cmd.wdata;
        return {cmd.rw, cmd.addr, data};
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Command queue: synchronous FIFO with registered empty and not-full flags, no bypass path.
module spi_cmd_fifo
    import spi_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  cmd_t wr_data_i,
    input  logic pop_i,
    output cmd_t rd_data_c,
    output logic empty_o,
    output logic ready_o
);

    localparam int unsigned cPtrWidth = $clog2(cFifoDepth);
    localparam int unsigned cCntW     = cPtrWidth + 1;

    cmd_t                 mem_q [cFifoDepth];
    logic [cPtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [cPtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [cCntW-1:0]     count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 ready_q, ready_d;
    logic                 push_en_c;
    logic                 pop_en_c;

    assign push_en_c = push_i && ready_q;
    assign pop_en_c  = pop_i && !empty_q;
    assign rd_data_c = mem_q[rd_ptr_q];
    assign empty_o   = empty_q;
    assign ready_o   = ready_q;

    // Flags derive from the next count so they line up with the pointer update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en_c) begin
            wr_ptr_d = wr_ptr_q + cPtrWidth'(1);
        end
        if (pop_en_c) begin
            rd_ptr_d = rd_ptr_q + cPtrWidth'(1);
        end
        count_d = count_q + cCntW'(push_en_c) - cCntW'(pop_en_c);
        empty_d = (count_d == '0);
        ready_d = (count_d != cCntW'(cFifoDepth));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Register-access front end for spi_serdes: queues commands, frames each one as a 16-bit
// transfer with CSB framing through the serdes reset, and returns one response per command.
module spi_cmd_sequencer
    import spi_seq_pkg::*;
(
    input  logic                   sys_clock_i,
    input  logic                   sys_reset_n_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_rw_i,
    input  logic [cAddrWidth-1:0]  cmd_addr_i,
    input  logic [cDataWidth-1:0]  cmd_wdata_i,
    output logic                   rsp_valid_o,
    output logic [cDataWidth-1:0]  rsp_rdata_o,
    output logic [cAddrWidth-1:0]  rsp_addr_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic                   ser_reset_o,
    output logic                   ser_start_o,
    output logic [cFrameWidth-1:0] ser_data_o,
    input  logic [cFrameWidth-1:0] ser_data_i,
    input  logic                   ser_done_i
);

    state_e                 state_q, state_d;
    logic [cCntWidth-1:0]   cnt_q, cnt_d;
    logic                   seen_low_q, seen_low_d;
    logic [cFrameWidth-1:0] frame_q, frame_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [cDataWidth-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [cAddrWidth-1:0]  rsp_addr_q, rsp_addr_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   busy_q, busy_d;
    logic                   ser_reset_q, ser_reset_d;
    logic                   ser_start_q, ser_start_d;

    cmd_t                   push_cmd_c;
    cmd_t                   fifo_head_c;
    logic                   fifo_push_c;
    logic                   fifo_pop_c;
    logic                   fifo_empty;
    logic                   fifo_ready;
    logic [cFrameWidth-cDataWidth-1:0] ser_data_unused;

    // Only the low byte of the received frame carries read data.
    assign ser_data_unused = ser_data_i[cFrameWidth-1:cDataWidth];

    assign push_cmd_c  = '{rw: cmd_rw_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    assign fifo_push_c = cmd_valid_i && fifo_ready;

    spi_cmd_fifo u_fifo (
        .clk       (sys_clock_i),
        .rst_n     (sys_reset_n_i),
        .push_i    (fifo_push_c),
        .wr_data_i (push_cmd_c),
        .pop_i     (fifo_pop_c),
        .rd_data_c (fifo_head_c),
        .empty_o   (fifo_empty),
        .ready_o   (fifo_ready)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen_low_d  = seen_low_q;
        frame_d     = frame_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop_c = 1'b1;
                    frame_d    = build_frame(fifo_head_c);
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_START;
            end
            ST_START: begin
                cnt_d      = '0;
                seen_low_d = 1'b0;
                state_d    = ST_BUSY;
            end
            ST_BUSY: begin
                cnt_d = cnt_q + cCntWidth'(1);
                if (!ser_done_i) begin
                    seen_low_d = 1'b1;
                end
                // done high without a prior low (stuck high) or budget exhausted both abort
                if (ser_done_i && seen_low_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = frame_q[cRwBit] ? ser_data_i[cDataMsb:cDataLsb] : '0;
                    rsp_addr_d  = frame_q[cAddrMsb:cAddrLsb];
                    cnt_d       = '0;
                    state_d     = ST_GAP;
                end else if (ser_done_i || (cnt_q == cCntWidth'(cTimeoutCycles - 1))) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_addr_d  = frame_q[cAddrMsb:cAddrLsb];
                    cnt_d       = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == cCntWidth'(cGapCycles - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + cCntWidth'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        ser_reset_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
        ser_start_d = (state_d == ST_START);
    end

    always_ff @(posedge sys_clock_i) begin
        if (!sys_reset_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            seen_low_q  <= 1'b0;
            frame_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            ser_reset_q <= 1'b1;
            ser_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seen_low_q  <= seen_low_d;
            frame_q     <= frame_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            ser_reset_q <= ser_reset_d;
            ser_start_q <= ser_start_d;
        end
    end

    assign cmd_ready_o = fifo_ready;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign ser_reset_o = ser_reset_q;
    assign ser_start_o = ser_start_q;
    assign ser_data_o  = frame_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a behavioural spi_serdes model.
module tb_spi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [6:0]  rsp_addr;
    logic        rsp_err;
    logic        busy;
    logic        ser_reset;
    logic        ser_start;
    logic [15:0] ser_data_o;
    logic [15:0] ser_data_i;
    logic        ser_done;

    localparam int GAP = 4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] rdata;
        logic [6:0] addr;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          start_q[$];
    logic [15:0] frame_q[$];
    int          gap_q[$];
    int          hi_run = 0;

    // serdes model: 0 healthy, 1 done stuck high, 2 done stuck low after start
    int          mode = 0;
    logic [7:0]  slave_byte = 8'h00;
    int          mcnt;
    logic        mdone;

    always #5 clk = ~clk;

    spi_cmd_sequencer dut (
        .sys_clock_i   (clk),
        .sys_reset_n_i (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_rw_i      (cmd_rw),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_addr_o    (rsp_addr),
        .rsp_err_o     (rsp_err),
        .busy_o        (busy),
        .ser_reset_o   (ser_reset),
        .ser_start_o   (ser_start),
        .ser_data_o    (ser_data_o),
        .ser_data_i    (ser_data_i),
        .ser_done_i    (ser_done)
    );

    assign ser_done   = mdone;
    assign ser_data_i = {8'hC3, slave_byte};

    always @(posedge clk) begin
        if (!rst_n || ser_reset) begin
            mdone <= 1'b1;
            mcnt  <= 0;
        end else if (ser_start) begin
            if (mode == 0) begin
                mcnt  <= 16;
                mdone <= 1'b0;
            end else if (mode == 2) begin
                mdone <= 1'b0;
            end
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1) begin
            mcnt  <= 0;
            mdone <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples each cycle's values at the edge that ends it.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && ser_start === 1'b1) begin
            start_q.push_back(cyc);
            frame_q.push_back(ser_data_o);
            check("start_protocol", 32'({ser_reset, ser_done}), 32'h1);
        end
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            rsp_q.push_back('{cyc: cyc, err: rsp_err, rdata: rsp_rdata, addr: rsp_addr});
        end
        if (rst_n === 1'b1 && ser_reset === 1'b1) begin
            hi_run++;
        end else if (rst_n === 1'b1 && ser_reset === 1'b0 && hi_run > 0) begin
            gap_q.push_back(hi_run);
            hi_run = 0;
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d, output int waited);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        waited    = 0;
        while (!cmd_ready && waited < 200) begin
            step(1);
            waited++;
        end
        check("push_accept", 32'(cmd_ready), 32'h1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n);
        int k = 0;
        while (start_q.size() < n && k < 500) begin
            step(1);
            k++;
        end
        check("start_seen", 32'(start_q.size() >= n), 32'h1);
    endtask

    task automatic wait_rsps(input int n);
        int k = 0;
        while (rsp_q.size() < n && k < 500) begin
            step(1);
            k++;
        end
        check("rsp_seen", 32'(rsp_q.size() >= n), 32'h1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            step(1);
            k++;
        end
        check("idle_reached", 32'(busy), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},     32'(cmd_ready),  32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid),  32'h0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata),  32'h0);
        check({tag, "_rsp_addr"},  32'(rsp_addr),   32'h0);
        check({tag, "_rsp_err"},   32'(rsp_err),    32'h0);
        check({tag, "_busy"},      32'(busy),       32'h0);
        check({tag, "_ser_reset"}, 32'(ser_reset),  32'h1);
        check({tag, "_ser_start"}, 32'(ser_start),  32'h0);
        check({tag, "_ser_data"},  32'(ser_data_o), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int ns;
        int nr;
        int s;
        int k;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        // Reset values
        step(3);
        check_reset_outputs("por");
        rst_n = 1'b1;
        step(1);
        check("ready_after_release", 32'(cmd_ready), 32'h1);

        // Single write 0x12 <- 0xA5
        push(1'b0, 7'h12, 8'hA5, w);
        wait_starts(1);
        check("wr_frame", 32'(frame_q[0]), 32'h12A5);
        wait_rsps(1);
        check("wr_rsp_addr",  32'(rsp_q[0].addr),  32'h12);
        check("wr_rsp_err",   32'(rsp_q[0].err),   32'h0);
        check("wr_rsp_rdata", 32'(rsp_q[0].rdata), 32'h0);
        check("wr_rsp_lat",   32'(rsp_q[0].cyc - start_q[0]), 32'd18);
        wait_idle();
        check("wr_one_rsp", 32'(rsp_q.size()), 32'd1);
        check("idle_csb_high", 32'(ser_reset), 32'h1);

        // Read 0x7F, slave returns 0x3C; write data must not reach the wire
        slave_byte = 8'h3C;
        push(1'b1, 7'h7F, 8'h5A, w);
        wait_starts(2);
        check("rd_frame", 32'(frame_q[1]), 32'hFF00);
        wait_rsps(2);
        check("rd_rsp_addr",  32'(rsp_q[1].addr),  32'h7F);
        check("rd_rsp_err",   32'(rsp_q[1].err),   32'h0);
        check("rd_rsp_rdata", 32'(rsp_q[1].rdata), 32'h3C);
        check("rd_rsp_lat",   32'(rsp_q[1].cyc - start_q[1]), 32'd18);
        wait_idle();

        // Back-to-back: five pushes fill the queue behind the in-flight one, sixth must wait
        gap_q.delete();
        ns = start_q.size();
        nr = rsp_q.size();
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 7'(7'h20 + i), 8'(8'h30 + i), w);
            check("b2b_no_wait", 32'(w), 32'h0);
        end
        check("b2b_full_ready", 32'(cmd_ready), 32'h0);
        push(1'b0, 7'h25, 8'h35, w);
        check("b2b_sixth_waited", 32'(w > 5), 32'h1);
        wait_rsps(nr + 6);
        for (int i = 0; i < 6; i++) begin
            check("b2b_order_addr", 32'(rsp_q[nr + i].addr), 32'(7'h20 + i));
            check("b2b_err",        32'(rsp_q[nr + i].err),  32'h0);
        end
        wait_starts(ns + 6);
        check("b2b_frame5", 32'(frame_q[ns + 5]), 32'h2535);
        for (int i = 1; i < 6; i++) begin
            check("b2b_csb_gap", 32'(gap_q[i] >= GAP && gap_q[i] <= GAP + 2), 32'h1);
        end
        wait_idle();

        // ser_done stuck high: error right after the first BUSY cycle, next command proceeds
        mode = 1;
        slave_byte = 8'h99;
        ns = start_q.size();
        nr = rsp_q.size();
        push(1'b1, 7'h33, 8'h44, w);
        wait_rsps(nr + 1);
        wait_starts(ns + 1);
        check("hi_err",   32'(rsp_q[nr].err),   32'h1);
        check("hi_rdata", 32'(rsp_q[nr].rdata), 32'h0);
        check("hi_addr",  32'(rsp_q[nr].addr),  32'h33);
        check("hi_lat",   32'(rsp_q[nr].cyc - start_q[ns]), 32'd2);
        mode = 0;
        push(1'b0, 7'h34, 8'h55, w);
        wait_rsps(nr + 2);
        check("hi_next_err",  32'(rsp_q[nr + 1].err),  32'h0);
        check("hi_next_addr", 32'(rsp_q[nr + 1].addr), 32'h34);
        wait_idle();

        // ser_done stuck low: timeout after the full BUSY budget
        mode = 2;
        ns = start_q.size();
        nr = rsp_q.size();
        push(1'b1, 7'h40, 8'h00, w);
        wait_rsps(nr + 1);
        wait_starts(ns + 1);
        check("lo_err",   32'(rsp_q[nr].err),   32'h1);
        check("lo_rdata", 32'(rsp_q[nr].rdata), 32'h0);
        check("lo_addr",  32'(rsp_q[nr].addr),  32'h40);
        check("lo_lat",   32'(rsp_q[nr].cyc - start_q[ns]), 32'd65);
        mode = 0;
        wait_idle();

        // Reset in frame cycle 10 with two commands still queued
        ns = start_q.size();
        nr = rsp_q.size();
        push(1'b0, 7'h50, 8'h01, w);
        push(1'b0, 7'h51, 8'h02, w);
        push(1'b0, 7'h52, 8'h03, w);
        wait_starts(ns + 1);
        s = start_q[ns];
        k = 0;
        while (cyc < s + 8 && k < 100) begin
            step(1);
            k++;
        end
        check("rst_at_cycle10", 32'(cyc), 32'(s + 8));
        rst_n = 1'b0;
        step(1);
        check_reset_outputs("midrst");
        step(2);
        rst_n = 1'b1;
        step(1);
        check("midrst_ready_after_release", 32'(cmd_ready), 32'h1);
        step(30);
        check("midrst_no_rsp",    32'(rsp_q.size()),   32'(nr));
        check("midrst_fifo_empty", 32'(start_q.size()), 32'(ns + 1));
        check("midrst_idle_busy", 32'(busy),           32'h0);
        check("midrst_csb_high",  32'(ser_reset),      32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
